uart_int_status: RTL and testbench

//  Source side of the UART interrupt path. Turns raw FIFO/parity status into

---
 rtl/uart_int_status.sv | 67 ++++++
 tb/tb_uart_int_status.sv | 129 ++++++++++++
 2 files changed

// File: rtl/uart_int_status.sv
// uart_int_status: sticky W1C interrupt status, enable gating into pending bits,
// and a registered IRQ line that enforces a minimum low gap after each deassert.
module uart_int_status #(
  parameter int unsigned        NUM_SRC   = 5,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '1,
  parameter int unsigned        IRQ_GAP   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] evt_i,
  input  logic [NUM_SRC-1:0] int_en,
  input  logic               clr_we,
  input  logic [NUM_SRC-1:0] clr_data,
  output logic [NUM_SRC-1:0] sts_o,
  output logic [NUM_SRC-1:0] pend_o,
  output logic               irq_o
);
  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_e;
  localparam logic [3:0] GAP_N = 4'(IRQ_GAP);
  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] evt_q, sts_q, sts_d, set, clr;
  logic [3:0]         cnt_q, cnt_d;
  logic               irq_q, irq_d;
  // set wins over clear so an event coinciding with a W1C is never lost
  always_comb begin
    set   = (EDGE_MASK & evt_i & ~evt_q) | (~EDGE_MASK & evt_i);
    clr   = clr_we ? clr_data : '0;
    sts_d = (sts_q & ~clr) | set;
  end
  assign sts_o  = sts_q;
  assign pend_o = sts_q & int_en;
  assign irq_o  = irq_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    state_d = |pend_o ? ASSERT : IDLE;
      ASSERT: begin
        if (~|pend_o) begin
          state_d = (GAP_N == 4'd0) ? IDLE : GAP;
          cnt_d   = GAP_N;
        end
      end
      GAP: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
    irq_d = (state_d == ASSERT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q   <= '0;
      sts_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      evt_q   <= evt_i;
      sts_q   <= sts_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end
endmodule

// File: tb/tb_uart_int_status.sv
// tb_uart_int_status: directed vectors; expectations queued by the driver and
// checked by a monitor one edge later.
module tb_uart_int_status;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] evt_i = 5'b01010, int_en = '0, clr_data = '0;
  logic       clr_we = 1'b0;
  logic [4:0] sts_o, pend_o;
  logic       irq_o;
  int         n_chk = 0, n_fail = 0;
  typedef struct {
    logic [4:0] sts;
    logic [4:0] pend;
    logic       irq;
    string      nm;
  } exp_t;
  exp_t q[$];

  uart_int_status dut (
    .clk(clk), .rst(rst), .evt_i(evt_i), .int_en(int_en), .clr_we(clr_we),
    .clr_data(clr_data), .sts_o(sts_o), .pend_o(pend_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // inputs change at negedge; expectations describe the state after the next posedge
  task automatic cyc(input logic [4:0] evt, input logic [4:0] en, input logic we,
                     input logic [4:0] cd, input logic [4:0] es, input logic [4:0] ep,
                     input logic ei, input string nm);
    exp_t e;
    evt_i = evt; int_en = en; clr_we = we; clr_data = cd;
    e.sts = es; e.pend = ep; e.irq = ei; e.nm = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".sts"}, sts_o, e.sts);
      chk({e.nm, ".pend"}, pend_o, e.pend);
      chk({e.nm, ".irq"}, {4'b0, irq_o}, {4'b0, e.irq});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.sts", sts_o, 5'b0);
    chk("rst.irq", {4'b0, irq_o}, 5'b0);
    rst = 1'b0;
    cyc(5'b01010, 5'b0, 0, 5'b0, 5'b01010, 5'b0, 0, "rst_rel");
    cyc(5'b01010, 5'b0, 0, 5'b0, 5'b01010, 5'b0, 0, "no_en");
    cyc(5'b01010, 5'b0, 1, 5'b01010, 5'b0, 5'b0, 0, "w1c_init");
    // parity pulse, then W1C and the minimum low gap
    cyc(5'b11010, 5'b10000, 0, 5'b0, 5'b10000, 5'b10000, 0, "par_sts");
    cyc(5'b01010, 5'b10000, 0, 5'b0, 5'b10000, 5'b10000, 1, "par_irq");
    cyc(5'b01010, 5'b10000, 1, 5'b10000, 5'b0, 5'b0, 1, "w1c_par");
    cyc(5'b01010, 5'b10000, 0, 5'b0, 5'b0, 5'b0, 0, "gap0");
    for (int i = 0; i < 5; i++) cyc(5'b01010, 5'b10000, 0, 5'b0, 5'b0, 5'b0, 0, "gap_low");
    // rising edge and W1C in the same cycle
    cyc(5'b01110, 5'b00100, 0, 5'b0, 5'b00100, 5'b00100, 0, "rx_sts");
    cyc(5'b01110, 5'b00100, 0, 5'b0, 5'b00100, 5'b00100, 1, "rx_irq");
    cyc(5'b01010, 5'b00100, 0, 5'b0, 5'b00100, 5'b00100, 1, "rx_fall");
    cyc(5'b01110, 5'b00100, 1, 5'b00100, 5'b00100, 5'b00100, 1, "set_vs_clr");
    cyc(5'b01110, 5'b00100, 0, 5'b0, 5'b00100, 5'b00100, 1, "rx_hold");
    cyc(5'b01110, 5'b00100, 1, 5'b00100, 5'b0, 5'b0, 1, "rx_clr");
    cyc(5'b01110, 5'b00100, 0, 5'b0, 5'b0, 5'b0, 0, "rx_gap");
    for (int i = 0; i < 4; i++) cyc(5'b01110, 5'b00100, 0, 5'b0, 5'b0, 5'b0, 0, "rx_gap_low");
    // two pending, partial clears, new event during the gap
    cyc(5'b11111, 5'b10001, 0, 5'b0, 5'b10001, 5'b10001, 0, "two_sts");
    cyc(5'b11111, 5'b10001, 0, 5'b0, 5'b10001, 5'b10001, 1, "two_irq");
    cyc(5'b11111, 5'b10001, 1, 5'b00001, 5'b10000, 5'b10000, 1, "part_clr");
    cyc(5'b11111, 5'b10001, 0, 5'b0, 5'b10000, 5'b10000, 1, "part_hold");
    cyc(5'b11111, 5'b10001, 1, 5'b00000, 5'b10000, 5'b10000, 1, "clr_zero");
    cyc(5'b11111, 5'b10001, 1, 5'b00010, 5'b10000, 5'b10000, 1, "clr_clear_bit");
    cyc(5'b11111, 5'b10001, 1, 5'b10000, 5'b0, 5'b0, 1, "clr_b4");
    cyc(5'b11111, 5'b10001, 0, 5'b0, 5'b0, 5'b0, 0, "deassert");
    cyc(5'b11110, 5'b10001, 0, 5'b0, 5'b0, 5'b0, 0, "g1");
    cyc(5'b11111, 5'b10001, 0, 5'b0, 5'b00001, 5'b00001, 0, "g2_evt");
    cyc(5'b11111, 5'b10001, 0, 5'b0, 5'b00001, 5'b00001, 0, "g3");
    cyc(5'b11111, 5'b10001, 0, 5'b0, 5'b00001, 5'b00001, 0, "g4");
    cyc(5'b11111, 5'b10001, 0, 5'b0, 5'b00001, 5'b00001, 1, "reassert");
    cyc(5'b11111, 5'b10001, 1, 5'b00001, 5'b0, 5'b0, 1, "clr_b0");
    cyc(5'b11111, 5'b10001, 0, 5'b0, 5'b0, 5'b0, 0, "deassert2");
    for (int i = 0; i < 4; i++) cyc(5'b11111, 5'b10001, 0, 5'b0, 5'b0, 5'b0, 0, "gap2_low");
    // status captured while disabled, then enabled and disabled
    cyc(5'b10111, 5'b0, 0, 5'b0, 5'b0, 5'b0, 0, "b3_fall");
    cyc(5'b11111, 5'b0, 0, 5'b0, 5'b01000, 5'b0, 0, "b3_sts");
    cyc(5'b11111, 5'b0, 0, 5'b0, 5'b01000, 5'b0, 0, "b3_noirq");
    int_en = 5'b01000;
    #1;
    chk("en_comb.pend", pend_o, 5'b01000);
    chk("en_comb.irq", {4'b0, irq_o}, 5'b0);
    cyc(5'b11111, 5'b01000, 0, 5'b0, 5'b01000, 5'b01000, 1, "en_irq");
    cyc(5'b11111, 5'b0, 0, 5'b0, 5'b01000, 5'b0, 0, "dis");
    for (int i = 0; i < 4; i++) cyc(5'b11111, 5'b0, 0, 5'b0, 5'b01000, 5'b0, 0, "dis_gap");
    cyc(5'b11111, 5'b01000, 0, 5'b0, 5'b01000, 5'b01000, 1, "reen");
    // asynchronous reset while asserted
    #2 rst = 1'b1;
    #1;
    chk("arst.irq", {4'b0, irq_o}, 5'b0);
    chk("arst.sts", sts_o, 5'b0);
    chk("arst.pend", pend_o, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc(5'b11111, 5'b01000, 0, 5'b0, 5'b11111, 5'b01000, 0, "post_rst");
    cyc(5'b11111, 5'b01000, 0, 5'b0, 5'b11111, 5'b01000, 1, "post_rst_irq");
    @(negedge clk);
    chk("queue_drained", 5'(q.size()), 5'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
